bin2bcd_seq: RTL and testbench

Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, processing one bit per clock. It generalises the fixed 8-bit/3-digit converter to arbitrary input width and digit count. It adds a valid/ready handshake on both sides, back-to-back operation without reset, an overflow flag, and an optional signed mode. It sits between binary sources (counters, switch-selected constants) and the 7-segment/TM1638 display driver.

---
 rtl/bin2bcd_seq.sv | 153 +++++++++++++++
 tb/tb_bin2bcd_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3, one bit
// per clock) with valid/ready handshakes on both sides and a sticky overflow
// flag. `out_bcd` holds the value modulo 10^DIGITS when `out_ovf` is set.
//
// Optional feature: define BIN2BCD_SIGNED_EN to treat `in_data` as two's
// complement. The magnitude is converted, and `out_neg` reports the sign.
// Without the macro, `out_neg` is tied to 0 and no negation logic exists.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf,
    output logic                  out_neg
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [BIN_W-1:0] sr_q, sr_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] obcd_q, obcd_d;
    logic             oovf_q, oovf_d;

    logic [ACC_W-1:0] acc_corr;
    logic [ACC_W-1:0] acc_shift;
    logic [BIN_W-1:0] load_val;

    // Per-digit add-3 correction; digits are independent, no carry between them.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        logic [3:0] d;
        assign d = acc_q[4*g +: 4];
        assign acc_corr[4*g +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end

    // The corrected top bit falls off here; the overflow flag captures it.
    assign acc_shift = {acc_corr[ACC_W-2:0], sr_q[BIN_W-1]};

`ifdef BIN2BCD_SIGNED_EN
    logic neg_q, neg_d;
    logic oneg_q, oneg_d;

    // Two's-complement magnitude; the most negative value maps onto
    // 2^(BIN_W-1), which is still representable as an unsigned BIN_W value.
    assign load_val = in_data[BIN_W-1] ? -in_data : in_data;
    assign out_neg  = oneg_q;
`else
    assign load_val = in_data;
    assign out_neg  = 1'b0;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_bcd   = obcd_q;
    assign out_ovf   = oovf_q;

    // Next-state logic for the FSM, datapath and output registers.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        obcd_d  = obcd_q;
        oovf_d  = oovf_q;
`ifdef BIN2BCD_SIGNED_EN
        neg_d   = neg_q;
        oneg_d  = oneg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sr_d    = load_val;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(BIN_W);
`ifdef BIN2BCD_SIGNED_EN
                    neg_d   = in_data[BIN_W-1];
`endif
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                acc_d = acc_shift;
                sr_d  = sr_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                ovf_d = ovf_q | acc_corr[ACC_W-1];
                if (cnt_q == CNT_W'(1)) begin
                    // Last shift: publish the result as DONE is entered.
                    obcd_d  = acc_shift;
                    oovf_d  = ovf_q | acc_corr[ACC_W-1];
`ifdef BIN2BCD_SIGNED_EN
                    oneg_d  = neg_q;
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            obcd_q  <= '0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            obcd_q  <= obcd_d;
            oovf_q  <= oovf_d;
        end
    end

`ifdef BIN2BCD_SIGNED_EN
    // Sign capture and its published copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_q  <= 1'b0;
            oneg_q <= 1'b0;
        end else begin
            neg_q  <= neg_d;
            oneg_q <= oneg_d;
        end
    end
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq. Two instances share the stimulus: a
// 3-digit one and a 2-digit one (the latter exercises overflow). Follows
// BIN2BCD_SIGNED_EN when it is defined for the build.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  in_data = '0;

    logic        in_ready, out_valid, out_ovf, out_neg;
    logic [11:0] out_bcd;
    logic        in_ready2, out_valid2, out_ovf2, out_neg2;
    logic [7:0]  out_bcd2;

    int n_chk = 0;
    int n_err = 0;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .out_ovf(out_ovf), .out_neg(out_neg)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
        .out_bcd(out_bcd2), .out_ovf(out_ovf2), .out_neg(out_neg2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: decimal digits by division, truncated to nd digits.
    function automatic logic [11:0] ref_bcd(input int m, input int nd);
        logic [11:0] r = '0;
        int p = 1;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'((m / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int ref_mag(input logic [7:0] v);
`ifdef BIN2BCD_SIGNED_EN
        return v[7] ? 256 - int'(v) : int'(v);
`else
        return int'(v);
`endif
    endfunction

    // Hand off one operand and wait for the result; leaves time at edge+1.
    task automatic convert(input logic [7:0] v);
        int w = 0;
        int lat = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("acc_rdy", in_ready, 1);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, 8);
        chk("vld2", out_valid2, 1);
    endtask

    logic [7:0]  dv  [6] = '{8'd243, 8'd0, 8'd5, 8'd76, 8'd198, 8'd255};
`ifdef BIN2BCD_SIGNED_EN
    logic [11:0] de  [6] = '{12'h013, 12'h000, 12'h005, 12'h076, 12'h058, 12'h001};
    logic        dn  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0]  sv  [3] = '{8'h80, 8'hFF, 8'h7F};
    logic [11:0] se  [3] = '{12'h128, 12'h001, 12'h127};
    logic        sn  [3] = '{1'b1, 1'b1, 1'b0};
`else
    logic [11:0] de  [6] = '{12'h243, 12'h000, 12'h005, 12'h076, 12'h198, 12'h255};
    logic        dn  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    initial begin
        logic [11:0] held;
        int m;

        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bcd", out_bcd, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_out_neg", out_neg, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed back-to-back vectors.
        for (int i = 0; i < 6; i++) begin
            convert(dv[i]);
            chk("dir_bcd", out_bcd, de[i]);
            chk("dir_ovf", out_ovf, 0);
            chk("dir_neg", out_neg, dn[i]);
            @(posedge clk); #1;
            chk("idle_next", in_ready, 1);
            chk("vld_drop", out_valid, 0);
        end

`ifndef BIN2BCD_SIGNED_EN
        // 2-digit overflow, then the flag clears for the next operand.
        convert(8'd198);
        chk("d2_198_bcd", out_bcd2, 8'h98);
        chk("d2_198_ovf", out_ovf2, 1);
        @(posedge clk); #1;
        convert(8'd99);
        chk("d2_99_bcd", out_bcd2, 8'h99);
        chk("d2_99_ovf", out_ovf2, 0);
        @(posedge clk); #1;
`else
        for (int i = 0; i < 3; i++) begin
            convert(sv[i]);
            chk("sgn_bcd", out_bcd, se[i]);
            chk("sgn_neg", out_neg, sn[i]);
            @(posedge clk); #1;
        end
`endif

        // Backpressure: result held, no re-accept while DONE.
        out_ready = 1'b0;
        convert(8'd76);
        held = out_bcd;
        chk("bp_first", held, 12'h076);
        in_valid = 1'b1;
        in_data  = 8'd5;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_vld", out_valid, 1);
            chk("bp_bcd", out_bcd, 12'h076);
            chk("bp_rdy", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_rdy", in_ready, 1);
        chk("bp_rel_vld", out_valid, 0);
        chk("bp_hold_idle", out_bcd, 12'h076);

        // Asynchronous reset in the middle of a conversion.
        in_valid = 1'b1;
        in_data  = 8'd198;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("ar_vld", out_valid, 0);
        chk("ar_bcd", out_bcd, 0);
        chk("ar_rdy", in_ready, 1);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        convert(8'd123);
        chk("ar_fresh", out_bcd, ref_bcd(ref_mag(8'd123), 3));
        @(posedge clk); #1;

        // Full sweep against the division model, both instances.
        for (int v = 0; v < 256; v++) begin
            m = ref_mag(8'(v));
            convert(8'(v));
            chk("sw_bcd", out_bcd, ref_bcd(m, 3));
            chk("sw_ovf", out_ovf, 0);
            chk("sw2_bcd", out_bcd2, ref_bcd(m, 2));
            chk("sw2_ovf", out_ovf2, (m >= 100) ? 1 : 0);
`ifdef BIN2BCD_SIGNED_EN
            chk("sw_neg", out_neg, (v >= 128) ? 1 : 0);
`else
            chk("sw_neg", out_neg, 0);
`endif
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
